// File: rtl/guess_entry_ctrl.sv
// Keypad front end and game controller for the two-digit number-guessing game.
// Debounces the one-hot keypad, builds a guess, checks it against the secret and counts tries.
`timescale 1ns/1ps
module guess_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_TRIES       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] onehot,
  input  logic [6:0]  secret,
  input  logic        new_game,
  output logic [3:0]  digit_hi,
  output logic [3:0]  digit_lo,
  output logic [7:0]  tries,
  output logic [1:0]  result,
  output logic        game_over,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, WIN, LOSE} state_t;

  localparam logic [15:0] DEB_LIMIT = 16'(DEBOUNCE_CYCLES);
  localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

  state_t      state, state_n;
  logic [15:0] prev_key, stable_cnt, cnt_next;
  logic        key_held, stable, key_evt;
  logic        key_valid, key_is_digit, key_enter, key_clear;
  logic [3:0]  key_digit;
  logic [3:0]  hi_n, lo_n;
  logic [1:0]  count, count_n;
  logic [7:0]  tries_n, tries_inc;
  logic [1:0]  result_n;
  logic [6:0]  secret_q, secret_n, guess_val;

  // Run length of identical samples, counting the current one; saturates at the limit.
  always_comb begin
    cnt_next = 16'd1;
    if (onehot == prev_key)
      cnt_next = (stable_cnt >= DEB_LIMIT) ? stable_cnt : stable_cnt + 16'd1;
  end

  assign stable  = (cnt_next >= DEB_LIMIT);
  assign key_evt = key_valid && stable && !key_held;

  always_comb begin
    key_valid    = 1'b0;
    key_is_digit = 1'b0;
    key_enter    = 1'b0;
    key_clear    = 1'b0;
    key_digit    = 4'd0;
    case (onehot)
      16'h0008: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd0; end
      16'h0080: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd1; end
      16'h0040: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd2; end
      16'h0020: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd3; end
      16'h0800: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd4; end
      16'h0400: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd5; end
      16'h0200: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd6; end
      16'h8000: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd7; end
      16'h4000: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd8; end
      16'h2000: begin key_valid = 1'b1; key_is_digit = 1'b1; key_digit = 4'd9; end
      16'h0001: begin key_valid = 1'b1; key_enter = 1'b1; end
      16'h0004: begin key_valid = 1'b1; key_clear = 1'b1; end
      default:  ;
    endcase
  end

  // Debounce state is deliberately untouched by new_game so a held key never re-fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_key   <= 16'd0;
      stable_cnt <= 16'd0;
      key_held   <= 1'b0;
    end else begin
      prev_key   <= onehot;
      stable_cnt <= cnt_next;
      if (key_evt)
        key_held <= 1'b1;
      else if (onehot == 16'd0 && stable)
        key_held <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      digit_hi <= 4'd0;
      digit_lo <= 4'd0;
      count    <= 2'd0;
      tries    <= 8'd0;
      result   <= 2'b00;
      secret_q <= 7'd0;
    end else begin
      state    <= state_n;
      digit_hi <= hi_n;
      digit_lo <= lo_n;
      count    <= count_n;
      tries    <= tries_n;
      result   <= result_n;
      secret_q <= secret_n;
    end
  end

  assign guess_val = 7'(digit_hi) * 7'd10 + 7'(digit_lo);
  assign tries_inc = tries + 8'd1;

  always_comb begin
    state_n  = state;
    hi_n     = digit_hi;
    lo_n     = digit_lo;
    count_n  = count;
    tries_n  = tries;
    result_n = result;
    secret_n = secret_q;
    if (new_game) begin
      secret_n = (secret > 7'd99) ? 7'd99 : secret;
      tries_n  = 8'd0;
      result_n = 2'b00;
      hi_n     = 4'd0;
      lo_n     = 4'd0;
      count_n  = 2'd0;
      state_n  = ENTRY;
    end else begin
      case (state)
        ENTRY: begin
          if (key_evt) begin
            if (key_is_digit) begin
              lo_n = key_digit;
              if (count != 2'd0) hi_n = digit_lo;
              if (count != 2'd2) count_n = count + 2'd1;
            end else if (key_clear) begin
              hi_n    = 4'd0;
              lo_n    = 4'd0;
              count_n = 2'd0;
            end else if (key_enter && count != 2'd0) begin
              state_n = CHECK;
            end
          end
        end
        CHECK: begin
          tries_n = tries_inc;
          if (guess_val == secret_q) begin
            result_n = 2'b11;
            state_n  = WIN;
          end else begin
            result_n = (guess_val < secret_q) ? 2'b01 : 2'b10;
            if (tries_inc == TRY_LIMIT) begin
              state_n = LOSE;
            end else begin
              hi_n    = 4'd0;
              lo_n    = 4'd0;
              count_n = 2'd0;
              state_n = ENTRY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign game_over = (state == WIN) || (state == LOSE);
  assign busy      = (state == ENTRY) || (state == CHECK);

endmodule

// File: doc/guess_entry_ctrl.md
Name: guess_entry_ctrl

Overview:
- Sequences the 4x4 keypad for the number-guessing game.
- Debounces the raw one-hot key vector and decodes it to digits and commands.
- Assembles a two-digit guess, compares it against a latched secret, and counts tries.
- Drives result, tries and digit outputs to the display/seven-segment path; owns the game state machine.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press or a release (legal range 1..65535).
- MAX_TRIES, 7: number of wrong guesses that ends the game in LOSE (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- onehot  in  16  raw keypad vector; 0 = no key pressed
- secret  in  7  secret number, sampled only on new_game
- new_game  in  1  single-cycle pulse; starts a new game
- digit_hi  out  4  tens digit of the current entry (BCD)
- digit_lo  out  4  units digit of the current entry (BCD)
- tries  out  8  guesses evaluated in the current game
- result  out  2  00 none, 01 too low, 10 too high, 11 correct
- game_over  out  1  high in WIN or LOSE
- busy  out  1  high in ENTRY or CHECK

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; secret register 0; debounce counter 0; key-held flag 0; digit count 0.
- Key decode (valid one-hot only; any other nonzero onehot value is treated as "no key" and restarts debounce):
  - Digits: 0008=0, 0080=1, 0040=2, 0020=3, 0800=4, 0400=5, 0200=6, 8000=7, 4000=8, 2000=9.
  - Commands: 0001=ENTER, 0004=CLEAR.
  - All other single bits are ignored keys.
- Debounce:
  - Counter resets whenever onehot differs from its value in the previous cycle.
  - Press accepted when the same valid code has been stable for DEBOUNCE_CYCLES cycles while key-held=0.
  - On acceptance, emit a one-cycle internal key event and set key-held=1.
  - Key-held clears only after onehot==0 has been stable for DEBOUNCE_CYCLES cycles.
  - Holding a key produces exactly one event.
- State machine:
  - IDLE: ignores key events. new_game goes to ENTRY.
  - ENTRY, digit event:
    - count=0: digit_lo<=d.
    - count>=1: digit_hi<=digit_lo, digit_lo<=d.
    - count saturates at 2; a third digit shifts and the oldest digit is lost.
  - ENTRY, CLEAR: digits and count go to 0; result is unchanged.
  - ENTRY, ENTER: ignored if count=0; otherwise go to CHECK.
  - CHECK (exactly one cycle): value = digit_hi*10 + digit_lo, computed as 7-bit unsigned; tries<=tries+1.
    - value==secret: result<=11, go to WIN.
    - value<secret: result<=01.
    - value>secret: result<=10.
    - Mismatch and tries+1==MAX_TRIES: go to LOSE.
    - Mismatch otherwise: clear digits and count, return to ENTRY.
  - WIN/LOSE: hold all outputs and ignore keys. new_game restarts.
- Latency: ENTER event on cycle N -> CHECK on cycle N+1 -> result, tries and state updated and visible from cycle N+2.
- new_game (any state, including CHECK):
  - Highest priority; overrides a coincident key event.
  - Next cycle: secret register <= min(secret, 99); tries=0; result=00; digits=0; count=0; state ENTRY.
  - Debounce and key-held state are not reset, so a key held across new_game does not re-fire.
- game_over = (state==WIN || state==LOSE). busy = (state==ENTRY || state==CHECK).
- rst mid-game: immediate return to reset values, regardless of key activity.

Test Plan (DEBOUNCE_CYCLES=4, MAX_TRIES=3):
- Bounce: rst, new_game with secret=42; onehot toggles 0800/0000 every 2 cycles, then holds 0800 for 10 cycles -> exactly one event; digit_lo=4 after the 4th stable cycle; no change while held.
- Win: keys 4, 2, ENTER, each press/release stable for 6 cycles -> digit_hi=4, digit_lo=2; result=11, tries=1, game_over=1 two cycles after the ENTER event; further keys ignored.
- High/low: secret=50; enter 7,3,ENTER -> result=10, tries=1, digits 0; enter 0,9,ENTER -> result=01, tries=2, busy=1.
- Lose: secret=5; wrong guesses 1, 2, 3 -> after the 3rd, result=01, tries=3, game_over=1, state LOSE; new_game with secret=120 -> latched value 99, tries=0, result=00.
- Shift/clear/invalid: enter 1,2,3 -> digit_hi=2, digit_lo=3; CLEAR -> 0/0; ENTER with count 0 -> no CHECK, tries unchanged; onehot=0011 held 10 cycles -> no event; key 0010 -> ignored.
- Reset mid-operation: assert rst during CHECK and while a key is held -> all outputs 0 immediately, state IDLE; keys ignored until new_game.
